// File: rtl/regfile_write_scheduler_if.sv
// ---------------------------------------------------------------------------
// regfile_write_scheduler_if : requester bus and register-file write ports
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface regfile_write_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
);
  logic [2:0]          req_valid;
  logic [3*ADDR_W-1:0] req_rd;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          req_ready;
  logic                wr1_en;
  logic [ADDR_W-1:0]   wr1_rd;
  logic [DATA_W-1:0]   wr1_data;
  logic                wr2_en;
  logic [ADDR_W-1:0]   wr2_rd;
  logic [DATA_W-1:0]   wr2_data;
  logic [1:0]          rr_ptr;
  logic [CNT_W-1:0]    conflict_cnt;

  modport master (
    output req_valid, req_rd, req_data,
    input  req_ready, wr1_en, wr1_rd, wr1_data,
    input  wr2_en, wr2_rd, wr2_data, rr_ptr, conflict_cnt
  );

  modport slave (
    input  req_valid, req_rd, req_data,
    output req_ready, wr1_en, wr1_rd, wr1_data,
    output wr2_en, wr2_rd, wr2_data, rr_ptr, conflict_cnt
  );
endinterface

`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_write_scheduler : round-robin arbiter of 3 writeback sources onto 2 RF write ports
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_write_scheduler #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic reset,
  regfile_write_scheduler_if.slave bus
);

  logic [ADDR_W-1:0] w_rd   [3];
  logic [DATA_W-1:0] w_data [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
    assign w_rd[gi]   = bus.req_rd[gi*ADDR_W +: ADDR_W];
    assign w_data[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  logic [1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr1_en_q, wr1_en_d, wr2_en_q, wr2_en_d;
  logic [ADDR_W-1:0] wr1_rd_q, wr1_rd_d, wr2_rd_q, wr2_rd_d;
  logic [DATA_W-1:0] wr1_data_q, wr1_data_d, wr2_data_q, wr2_data_d;

  logic       w_a_vld, w_b_vld, w_stall;
  logic [1:0] w_a_idx, w_b_idx, w_last;
  logic [2:0] w_ready;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] t;
    t = (v >= 3'd3) ? v - 3'd3 : v;
    return t[1:0];
  endfunction

  // Scan from the pointer; later requesters sharing A's rd are stalled, not granted.
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    w_a_vld = 1'b0;
    w_a_idx = '0;
    w_b_vld = 1'b0;
    w_b_idx = '0;
    w_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = wrap3({1'b0, ptr_q} + 3'(k));
      if (bus.req_valid[idx] && (w_rd[idx] != '0)) begin
        if (!w_a_vld) begin
          w_a_vld = 1'b1;
          w_a_idx = idx;
        end else if (w_rd[idx] == w_rd[w_a_idx]) begin
          w_stall = 1'b1;
        end else if (!w_b_vld) begin
          w_b_vld = 1'b1;
          w_b_idx = idx;
        end
      end
    end
  end

  // Writes to r0 are swallowed immediately and never touch a port or the pointer.
  always_comb begin
    w_ready = '0;
    for (int k = 0; k < 3; k++) begin
      if (bus.req_valid[k] && (w_rd[k] == '0)) begin
        w_ready[k] = 1'b1;
      end
    end
    if (w_a_vld) w_ready[w_a_idx] = 1'b1;
    if (w_b_vld) w_ready[w_b_idx] = 1'b1;
  end

  always_comb begin
    w_last     = w_b_vld ? w_b_idx : w_a_idx;
    ptr_d      = ptr_q;
    if (w_a_vld) begin
      ptr_d = (w_last == 2'd2) ? 2'd0 : w_last + 2'd1;
    end
    cnt_d      = (w_stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    wr1_en_d   = w_a_vld;
    wr1_rd_d   = w_a_vld ? w_rd[w_a_idx]   : wr1_rd_q;
    wr1_data_d = w_a_vld ? w_data[w_a_idx] : wr1_data_q;
    wr2_en_d   = w_b_vld;
    wr2_rd_d   = w_b_vld ? w_rd[w_b_idx]   : wr2_rd_q;
    wr2_data_d = w_b_vld ? w_data[w_b_idx] : wr2_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      wr1_en_q   <= 1'b0;
      wr1_rd_q   <= '0;
      wr1_data_q <= '0;
      wr2_en_q   <= 1'b0;
      wr2_rd_q   <= '0;
      wr2_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      wr1_en_q   <= wr1_en_d;
      wr1_rd_q   <= wr1_rd_d;
      wr1_data_q <= wr1_data_d;
      wr2_en_q   <= wr2_en_d;
      wr2_rd_q   <= wr2_rd_d;
      wr2_data_q <= wr2_data_d;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.wr1_en       = wr1_en_q;
  assign bus.wr1_rd       = wr1_rd_q;
  assign bus.wr1_data     = wr1_data_q;
  assign bus.wr2_en       = wr2_en_q;
  assign bus.wr2_rd       = wr2_rd_q;
  assign bus.wr2_data     = wr2_data_q;
  assign bus.rr_ptr       = ptr_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_scheduler : scoreboard bench with queue-based reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_write_scheduler;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  regfile_write_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  regfile_write_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        ready;
    logic              e1;
    logic [ADDR_W-1:0] rd1;
    logic [DATA_W-1:0] d1;
    logic              e2;
    logic [ADDR_W-1:0] rd2;
    logic [DATA_W-1:0] d2;
    logic [1:0]        ptr;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Requesters: each holds its request until the reference model says it was accepted.
  bit                p_v  [3];
  logic [ADDR_W-1:0] p_rd [3];
  logic [DATA_W-1:0] p_d  [3];

  // Reference model state.
  int                m_ptr;
  int                m_cnt;
  logic              m_e1, m_e2;
  logic [ADDR_W-1:0] m_rd1, m_rd2;
  logic [DATA_W-1:0] m_d1, m_d2;
  logic [2:0]        m_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic post(input int i, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    p_v[i]  = 1'b1;
    p_rd[i] = rd;
    p_d[i]  = d;
  endtask

  task automatic drive_bus();
    for (int i = 0; i < 3; i++) begin
      bus.req_valid[i]                  = p_v[i];
      bus.req_rd[i*ADDR_W +: ADDR_W]    = p_rd[i];
      bus.req_data[i*DATA_W +: DATA_W]  = p_d[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0;
    m_e1 = 1'b0; m_e2 = 1'b0;
    m_rd1 = '0; m_rd2 = '0; m_d1 = '0; m_d2 = '0;
    m_ready = '0;
  endtask

  // Apply the arbitration rules to the pending requests and queue the expected response.
  task automatic present();
    int   cand[$];
    int   a, b, i;
    bit   stall;
    exp_t e;
    m_ready = '0;
    for (int k = 0; k < 3; k++) begin
      i = (m_ptr + k) % 3;
      if (p_v[i]) begin
        if (p_rd[i] == '0) m_ready[i] = 1'b1;
        else               cand.push_back(i);
      end
    end
    a = -1; b = -1; stall = 1'b0;
    if (cand.size() > 0) begin
      a = cand[0];
      for (int j = 1; j < cand.size(); j++) begin
        if (p_rd[cand[j]] == p_rd[a]) stall = 1'b1;
        else if (b < 0)               b = cand[j];
      end
    end
    if (a >= 0) begin m_ready[a] = 1'b1; m_e1 = 1'b1; m_rd1 = p_rd[a]; m_d1 = p_d[a]; end
    else m_e1 = 1'b0;
    if (b >= 0) begin m_ready[b] = 1'b1; m_e2 = 1'b1; m_rd2 = p_rd[b]; m_d2 = p_d[b]; end
    else m_e2 = 1'b0;
    if (a >= 0) m_ptr = (((b >= 0) ? b : a) + 1) % 3;
    if (stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    e.ready = m_ready;
    e.e1 = m_e1; e.rd1 = m_rd1; e.d1 = m_d1;
    e.e2 = m_e2; e.rd2 = m_rd2; e.d2 = m_d2;
    e.ptr = 2'(m_ptr);
    e.cnt = CNT_W'(m_cnt);
    exp_q.push_back(e);
    drive_bus();
  endtask

  task automatic advance();
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) if (m_ready[i]) p_v[i] = 1'b0;
  endtask

  task automatic step();
    present();
    advance();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    for (int i = 0; i < 3; i++) p_v[i] = 1'b0;
    drive_bus();
    #1 reset = 1'b1;
    #1;
    chk("rst_wr1_en", 32'(bus.wr1_en), 0);
    chk("rst_wr2_en", 32'(bus.wr2_en), 0);
    chk("rst_rr_ptr", 32'(bus.rr_ptr), 0);
    chk("rst_cnt",    32'(bus.conflict_cnt), 0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // Monitor: ready is judged before the edge, registered outputs just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && !reset) begin
        e = exp_q[0];
        chk("req_ready", 32'(bus.req_ready), 32'(e.ready));
        @(posedge clk);
        #1;
        chk("wr1_en",   32'(bus.wr1_en),   32'(e.e1));
        chk("wr1_rd",   32'(bus.wr1_rd),   32'(e.rd1));
        chk("wr1_data", 32'(bus.wr1_data), 32'(e.d1));
        chk("wr2_en",   32'(bus.wr2_en),   32'(e.e2));
        chk("wr2_rd",   32'(bus.wr2_rd),   32'(e.rd2));
        chk("wr2_data", 32'(bus.wr2_data), 32'(e.d2));
        chk("rr_ptr",   32'(bus.rr_ptr),   32'(e.ptr));
        chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(e.cnt));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin p_v[i] = 1'b0; p_rd[i] = '0; p_d[i] = '0; end
    drive_bus();
    model_reset();
    #3 reset = 1'b1;
    #1;
    chk("init_wr1_en", 32'(bus.wr1_en), 0);
    chk("init_wr2_en", 32'(bus.wr2_en), 0);
    chk("init_rr_ptr", 32'(bus.rr_ptr), 0);
    chk("init_cnt",    32'(bus.conflict_cnt), 0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Idle after reset.
    repeat (5) begin
      present();
      #1 chk("idle_ready", 32'(bus.req_ready), 0);
      advance();
      chk("idle_wr1_en", 32'(bus.wr1_en), 0);
      chk("idle_wr2_en", 32'(bus.wr2_en), 0);
    end

    // Two distinct writes.
    do_reset();
    post(0, 5'd3, 8'h11); post(1, 5'd7, 8'h22);
    present();
    #1 chk("two_ready", 32'(bus.req_ready), 32'b011);
    advance();
    chk("two_wr1", {bus.wr1_en, 3'b0, bus.wr1_rd, bus.wr1_data}, {1'b1, 3'b0, 5'd3, 8'h11});
    chk("two_wr2", {bus.wr2_en, 3'b0, bus.wr2_rd, bus.wr2_data}, {1'b1, 3'b0, 5'd7, 8'h22});
    chk("two_ptr", 32'(bus.rr_ptr), 2);

    // Three valid requesters, distinct rds.
    do_reset();
    post(0, 5'd1, 8'h31); post(1, 5'd2, 8'h32); post(2, 5'd4, 8'h34);
    present();
    #1 chk("three_ready1", 32'(bus.req_ready), 32'b011);
    advance();
    chk("three_wr1_a", {bus.wr1_en, 3'b0, bus.wr1_rd, bus.wr1_data}, {1'b1, 3'b0, 5'd1, 8'h31});
    chk("three_wr2_a", {bus.wr2_en, 3'b0, bus.wr2_rd, bus.wr2_data}, {1'b1, 3'b0, 5'd2, 8'h32});
    chk("three_ptr_a", 32'(bus.rr_ptr), 2);
    present();
    #1 chk("three_ready2", 32'(bus.req_ready), 32'b100);
    advance();
    chk("three_wr1_b", {bus.wr1_en, 3'b0, bus.wr1_rd, bus.wr1_data}, {1'b1, 3'b0, 5'd4, 8'h34});
    chk("three_wr2_b", 32'(bus.wr2_en), 0);
    chk("three_ptr_b", 32'(bus.rr_ptr), 0);

    // Same-rd conflict between ALU0 and LSU.
    do_reset();
    post(0, 5'd5, 8'hAA); post(2, 5'd5, 8'hBB);
    present();
    #1 chk("conf_ready1", 32'(bus.req_ready), 32'b001);
    advance();
    chk("conf_wr1_a", {bus.wr1_en, 3'b0, bus.wr1_rd, bus.wr1_data}, {1'b1, 3'b0, 5'd5, 8'hAA});
    chk("conf_wr2_a", 32'(bus.wr2_en), 0);
    chk("conf_cnt_a", 32'(bus.conflict_cnt), 1);
    chk("conf_ptr_a", 32'(bus.rr_ptr), 1);
    present();
    #1 chk("conf_ready2", 32'(bus.req_ready), 32'b100);
    advance();
    chk("conf_wr1_b", {bus.wr1_en, 3'b0, bus.wr1_rd, bus.wr1_data}, {1'b1, 3'b0, 5'd5, 8'hBB});
    chk("conf_cnt_b", 32'(bus.conflict_cnt), 1);

    // Zero-register request beside a real write.
    do_reset();
    post(0, 5'd9, 8'h99); post(1, 5'd0, 8'h55);
    present();
    #1 chk("zero_ready", 32'(bus.req_ready), 32'b011);
    advance();
    chk("zero_wr1", {bus.wr1_en, 3'b0, bus.wr1_rd}, {1'b1, 3'b0, 5'd9});
    chk("zero_wr2_en", 32'(bus.wr2_en), 0);
    chk("zero_ptr", 32'(bus.rr_ptr), 1);

    // Persistent conflict drives the counter into saturation.
    do_reset();
    repeat (300) begin
      if (!p_v[0]) post(0, 5'd6, DATA_W'($urandom));
      if (!p_v[1]) post(1, 5'd6, DATA_W'($urandom));
      step();
    end
    chk("sat_cnt", 32'(bus.conflict_cnt), 255);
    chk("sat_wr1_en", 32'(bus.wr1_en), 1);

    // Randomized traffic with small rd range to provoke conflicts and r0 writes.
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!p_v[i] && ($urandom_range(0, 1) == 1))
          post(i, ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
      end
      step();
      if (cyc % 700 == 699) do_reset();
    end

    for (int i = 0; i < 3; i++) p_v[i] = 1'b0;
    drive_bus();
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
